// File: rtl/comm_pkg.sv
// Shared types and helpers for the link-quality monitor chain.
// Popcount and saturating add work on a 64-bit carrier; callers cast in and out.
package comm_pkg;

    localparam int DATA_W = 16;
    localparam int WIDE_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef logic [WIDE_W-1:0] wide_t;
    typedef logic [6:0]        pop_t;

    function automatic pop_t popcount(input wide_t v);
        pop_t n;
        n = '0;
        for (int i = 0; i < WIDE_W; i++) begin
            n = n + pop_t'(v[i]);
        end
        return n;
    endfunction

    function automatic wide_t sat_add(
        input wide_t a,
        input wide_t b,
        input wide_t max
    );
        logic [WIDE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[WIDE_W-1:0];
    endfunction

endpackage

// File: rtl/ref_fifo.sv
// Reference-word queue absorbing the transmit-to-decode pipeline latency.
// Pointers carry one extra wrap bit to tell full from empty.
module ref_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/ber_monitor.sv
// Bit-error-rate sink: queues source words, compares decoded words, keeps stats.
// Optional first-error frame capture under BER_MONITOR_FIRST_ERR_EN.
module ber_monitor #(
    parameter int DATA_W     = comm_pkg::DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32,
    parameter int NUM_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              ref_valid,
    input  logic [DATA_W-1:0] ref_data,
    input  logic              dec_valid,
    input  logic [DATA_W-1:0] dec_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_err_cnt,
    output logic [CNT_W-1:0]  frame_err_cnt,
    output logic [CNT_W-1:0]  frame_cnt,
`ifdef BER_MONITOR_FIRST_ERR_EN
    output logic [CNT_W-1:0]  first_err_frame,
    output logic              first_err_valid,
`endif
    output logic              fifo_ovf,
    output logic              fifo_udf
);

    import comm_pkg::*;

    localparam int               EW      = $clog2(DATA_W + 1);
    localparam wide_t            CNT_MAX = wide_t'({CNT_W{1'b1}});
    localparam logic [CNT_W-1:0] QUOTA   = CNT_W'(NUM_FRAMES);

    state_t            state_q, state_d;
    logic              upd_q, upd_d;
    logic [EW-1:0]     e_q, e_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  bit_err_cnt_q, bit_err_cnt_d;
    logic [CNT_W-1:0]  frame_err_cnt_q, frame_err_cnt_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              in_run, quota_hit, dec_take;
    logic              push, pop, full, empty;
    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  frame_inc;

    ref_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ref_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (push),
        .pop   (pop),
        .din   (ref_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Quota is judged on the value frame_cnt is about to take this cycle.
    always_comb begin
        in_run    = (state_q == ST_RUN);
        frame_inc = CNT_W'(sat_add(wide_t'(frame_cnt_q), wide_t'(1), CNT_MAX));
        quota_hit = in_run && upd_q && (NUM_FRAMES != 0) && (frame_inc == QUOTA);
        dec_take  = in_run && dec_valid && !quota_hit && !clear;
        pop       = dec_take && !empty;
        push      = in_run && ref_valid && !clear && (!full || pop);
        upd_d     = pop;
        e_d       = EW'(popcount(wide_t'(dec_data ^ head)));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (stop || quota_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    always_comb begin
        frame_cnt_d     = frame_cnt_q;
        bit_err_cnt_d   = bit_err_cnt_q;
        frame_err_cnt_d = frame_err_cnt_q;
        ovf_d = ovf_q || (in_run && ref_valid && full && !pop);
        udf_d = udf_q || (dec_take && empty);
        if (upd_q) begin
            frame_cnt_d     = frame_inc;
            bit_err_cnt_d   = CNT_W'(sat_add(wide_t'(bit_err_cnt_q),
                                             wide_t'(e_q), CNT_MAX));
            frame_err_cnt_d = CNT_W'(sat_add(wide_t'(frame_err_cnt_q),
                                             wide_t'(e_q != '0), CNT_MAX));
        end
        if (clear) begin
            frame_cnt_d     = '0;
            bit_err_cnt_d   = '0;
            frame_err_cnt_d = '0;
            ovf_d           = 1'b0;
            udf_d           = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            upd_q           <= 1'b0;
            e_q             <= '0;
            frame_cnt_q     <= '0;
            bit_err_cnt_q   <= '0;
            frame_err_cnt_q <= '0;
            ovf_q           <= 1'b0;
            udf_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            upd_q           <= upd_d;
            e_q             <= e_d;
            frame_cnt_q     <= frame_cnt_d;
            bit_err_cnt_q   <= bit_err_cnt_d;
            frame_err_cnt_q <= frame_err_cnt_d;
            ovf_q           <= ovf_d;
            udf_q           <= udf_d;
        end
    end

`ifdef BER_MONITOR_FIRST_ERR_EN
    logic [CNT_W-1:0] first_err_frame_q, first_err_frame_d;
    logic             first_err_valid_q, first_err_valid_d;

    // Index is the pre-increment count, i.e. the 0-based frame number.
    always_comb begin
        first_err_frame_d = first_err_frame_q;
        first_err_valid_d = first_err_valid_q;
        if (upd_q && (e_q != '0) && !first_err_valid_q) begin
            first_err_frame_d = frame_cnt_q;
            first_err_valid_d = 1'b1;
        end
        if (clear) begin
            first_err_frame_d = '0;
            first_err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_err_frame_q <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            first_err_frame_q <= first_err_frame_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign first_err_frame = first_err_frame_q;
    assign first_err_valid = first_err_valid_q;
`endif

    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign frame_cnt     = frame_cnt_q;
    assign bit_err_cnt   = bit_err_cnt_q;
    assign frame_err_cnt = frame_err_cnt_q;
    assign fifo_ovf      = ovf_q;
    assign fifo_udf      = udf_q;

endmodule

// File: tb/tb_ber_monitor.sv
// Directed bench for ber_monitor: a default instance plus a 4-frame quota one.
// Exercises first-error capture when BER_MONITOR_FIRST_ERR_EN is defined.
module tb_ber_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, clear;
    logic        ref_valid, dec_valid;
    logic [15:0] ref_data, dec_data;

    logic        busy, done, fifo_ovf, fifo_udf;
    logic [31:0] bit_err_cnt, frame_err_cnt, frame_cnt;
    logic        q_busy, q_done, q_ovf, q_udf;
    logic [31:0] q_bit_err, q_frame_err, q_frame_cnt;
`ifdef BER_MONITOR_FIRST_ERR_EN
    logic [31:0] first_err_frame, q_first_err_frame;
    logic        first_err_valid, q_first_err_valid;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ber_monitor u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .clear         (clear),
        .ref_valid     (ref_valid),
        .ref_data      (ref_data),
        .dec_valid     (dec_valid),
        .dec_data      (dec_data),
        .busy          (busy),
        .done          (done),
        .bit_err_cnt   (bit_err_cnt),
        .frame_err_cnt (frame_err_cnt),
        .frame_cnt     (frame_cnt),
`ifdef BER_MONITOR_FIRST_ERR_EN
        .first_err_frame (first_err_frame),
        .first_err_valid (first_err_valid),
`endif
        .fifo_ovf      (fifo_ovf),
        .fifo_udf      (fifo_udf)
    );

    ber_monitor #(.NUM_FRAMES(4)) u_quota (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .clear         (clear),
        .ref_valid     (ref_valid),
        .ref_data      (ref_data),
        .dec_valid     (dec_valid),
        .dec_data      (dec_data),
        .busy          (q_busy),
        .done          (q_done),
        .bit_err_cnt   (q_bit_err),
        .frame_err_cnt (q_frame_err),
        .frame_cnt     (q_frame_cnt),
`ifdef BER_MONITOR_FIRST_ERR_EN
        .first_err_frame (q_first_err_frame),
        .first_err_valid (q_first_err_valid),
`endif
        .fifo_ovf      (q_ovf),
        .fifo_udf      (q_udf)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear_start();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start = 0; stop = 0; clear = 0;
        ref_valid = 0; dec_valid = 0;
        ref_data = '0; dec_data = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_berr", bit_err_cnt, 0);
        chk("rst_ferr", frame_err_cnt, 0);
        chk("rst_ovf", fifo_ovf, 0);
        chk("rst_udf", fifo_udf, 0);
        rst = 1'b1;
        tick();

        // error-free frames with a gap between pushes and pops
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", busy, 1);
        ref_valid = 1; ref_data = 16'h147C;
        repeat (4) tick();
        ref_valid = 0;
        repeat (3) tick();
        dec_valid = 1; dec_data = 16'h147C;
        repeat (4) tick();
        dec_valid = 0;
        tick();
        chk("t1_fcnt", frame_cnt, 4);
        chk("t1_berr", bit_err_cnt, 0);
        chk("t1_ferr", frame_err_cnt, 0);
        chk("t1_ovf", fifo_ovf, 0);
        chk("t1_udf", fifo_udf, 0);

        // top nibble flipped: 4 bit errors, visible one cycle late
        ref_valid = 1; ref_data = 16'h147C;
        tick();
        ref_valid = 0;
        dec_valid = 1; dec_data = 16'hE47C;
        tick();
        dec_valid = 0;
        chk("t2_berr_lat", bit_err_cnt, 0);
        tick();
        chk("t2_berr", bit_err_cnt, 4);
        chk("t2_ferr", frame_err_cnt, 1);
        chk("t2_fcnt", frame_cnt, 5);

        // overflow, full push+pop, underflow, no bypass on empty
        do_clear_start();
        chk("t4_clr_fcnt", frame_cnt, 0);
        chk("t4_clr_ferr", frame_err_cnt, 0);
        ref_valid = 1;
        for (int i = 0; i < 8; i++) begin
            ref_data = 16'(i);
            tick();
        end
        ref_data = 16'd8; dec_valid = 1; dec_data = 16'd0;
        tick();
        chk("t4_full_pp_ovf", fifo_ovf, 0);
        ref_data = 16'd9; dec_valid = 0;
        tick();
        ref_valid = 0;
        chk("t4_ovf", fifo_ovf, 1);
        dec_valid = 1;
        for (int i = 1; i <= 8; i++) begin
            dec_data = 16'(i);
            tick();
        end
        dec_valid = 0;
        tick();
        chk("t4_fcnt9", frame_cnt, 9);
        chk("t4_berr0", bit_err_cnt, 0);
        chk("t4_udf0", fifo_udf, 0);
        dec_valid = 1;
        tick();
        dec_valid = 0;
        tick();
        chk("t4_udf", fifo_udf, 1);
        chk("t4_udf_fcnt", frame_cnt, 9);
        ref_valid = 1; ref_data = 16'hAAAA;
        dec_valid = 1; dec_data = 16'hAAAA;
        tick();
        ref_valid = 0; dec_valid = 0;
        tick();
        chk("t4_nobypass", frame_cnt, 9);
        dec_valid = 1;
        tick();
        dec_valid = 0;
        tick();
        chk("t4_stored", frame_cnt, 10);
        chk("t4_stored_berr", bit_err_cnt, 0);

        // frames 3 and 5 errored; first-error index must stick at 3
        do_clear_start();
`ifdef BER_MONITOR_FIRST_ERR_EN
        chk("t6_fev_clr", first_err_valid, 0);
`endif
        ref_valid = 1; ref_data = 16'h147C;
        repeat (6) tick();
        ref_valid = 0;
        dec_valid = 1;
        for (int f = 0; f < 6; f++) begin
            dec_data = (f == 3) ? 16'h147D : (f == 5) ? 16'h047C : 16'h147C;
            tick();
        end
        dec_valid = 0;
        tick();
        chk("t6_fcnt", frame_cnt, 6);
        chk("t6_berr", bit_err_cnt, 2);
        chk("t6_ferr", frame_err_cnt, 2);
`ifdef BER_MONITOR_FIRST_ERR_EN
        chk("t6_fev", first_err_valid, 1);
        chk("t6_fef", first_err_frame, 3);
`endif

        // quota of 4 on the second instance, 5 frames back-to-back
        do_clear_start();
        ref_valid = 1; ref_data = 16'h147C;
        repeat (5) tick();
        ref_valid = 0;
        dec_valid = 1; dec_data = 16'h147C;
        repeat (4) tick();
        chk("t3_fcnt3", q_frame_cnt, 3);
        chk("t3_done_early", q_done, 0);
        tick();
        dec_valid = 0;
        chk("t3_done", q_done, 1);
        chk("t3_busy", q_busy, 0);
        chk("t3_fcnt", q_frame_cnt, 4);
        chk("t3_udf", q_udf, 0);
        repeat (3) tick();
        chk("t3_frozen", q_frame_cnt, 4);

        // clear with stop and a live compare discards everything
        do_clear_start();
        ref_valid = 1; ref_data = 16'h147C;
        tick();
        ref_valid = 0;
        dec_valid = 1; dec_data = 16'hE47C;
        tick();
        tick();
        dec_valid = 0;
        chk("t5_pre_berr", bit_err_cnt, 4);
        chk("t5_pre_udf", fifo_udf, 1);
        ref_valid = 1;
        tick();
        ref_valid = 0;
        clear = 1; stop = 1; dec_valid = 1;
        tick();
        clear = 0; stop = 0; dec_valid = 0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_berr", bit_err_cnt, 0);
        chk("t5_udf", fifo_udf, 0);
        tick();
        chk("t5_discard", frame_cnt, 0);
        chk("t5_discard_ferr", frame_err_cnt, 0);

        // asynchronous reset mid-run, no clock edge in between
        start = 1;
        tick();
        start = 0;
        ref_valid = 1;
        tick();
        ref_valid = 0;
        dec_valid = 1;
        tick();
        dec_valid = 0;
        tick();
        chk("t5r_pre_berr", bit_err_cnt, 4);
        chk("t5r_pre_busy", busy, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("t5r_busy", busy, 0);
        chk("t5r_done", done, 0);
        chk("t5r_berr", bit_err_cnt, 0);
        chk("t5r_ferr", frame_err_cnt, 0);
        chk("t5r_fcnt", frame_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
